// File: rtl/flag_checker.sv
// Registered per-channel flag checker (level/sticky/edge/qualified), flags ORed with a global force.
// Latency: 1 edge (modes 00/01/10), THRESH edges of continuous high input (mode 11); no backpressure.
module flag_checker #(
    parameter int WIDTH  = 2,
    parameter int CNT_W  = 4,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enabling,
    input  logic [WIDTH-1:0] check,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic [WIDTH-1:0] checked,
    output logic             any_checked
);

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_STICKY = 2'b01,
        MODE_EDGE   = 2'b10,
        MODE_QUAL   = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [WIDTH-1:0]            eff;
    logic [WIDTH-1:0]            checked_d, checked_q;
    logic [WIDTH-1:0]            prev_d, prev_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d, cnt_q;
    mode_t                       mode_d, mode_q;
    logic [CNT_W-1:0]            cnt_n;

    assign eff = {WIDTH{enabling}} | check;

    always_comb begin
        checked_d = '0;
        cnt_d     = '0;
        cnt_n     = '0;
        prev_d    = eff;
        mode_d    = mode_t'(mode);

        // A mode change clears like an explicit clear, so counters enter every mode at zero.
        if (!clear && (mode_t'(mode) == mode_q)) begin
            case (mode_q)
                MODE_LEVEL:  checked_d = eff;
                MODE_STICKY: checked_d = checked_q | eff;
                MODE_EDGE:   checked_d = eff & ~prev_q;
                MODE_QUAL: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (!eff[i]) begin
                            cnt_n = '0;
                        end else if (cnt_q[i] >= THRESH_C) begin
                            cnt_n = THRESH_C;
                        end else begin
                            cnt_n = cnt_q[i] + ONE_C;
                        end
                        cnt_d[i]     = cnt_n;
                        checked_d[i] = (cnt_n == THRESH_C);
                    end
                end
                default: checked_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checked_q <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            mode_q    <= MODE_LEVEL;
        end else begin
            checked_q <= checked_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
        end
    end

    assign checked     = checked_q;
    assign any_checked = |checked_q;

endmodule

// File: tb/tb_flag_checker.sv
// Directed bench for flag_checker (WIDTH=2, CNT_W=4, THRESH=3) with immediate-assertion checks.
module tb_flag_checker;

    logic       clk;
    logic       reset;
    logic       enabling;
    logic [1:0] check;
    logic [1:0] mode;
    logic       clear;
    logic [1:0] checked;
    logic       any_checked;

    int checks = 0;
    int errors = 0;

    flag_checker #(.WIDTH(2), .CNT_W(4), .THRESH(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .enabling    (enabling),
        .check       (check),
        .mode        (mode),
        .clear       (clear),
        .checked     (checked),
        .any_checked (any_checked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] exp);
        logic exp_any;
        exp_any = exp[0] | exp[1];
        checks++;
        assert (checked === exp) else begin
            errors++;
            $error("FAIL %s checked got %b exp %b", tag, checked, exp);
        end
        checks++;
        assert (any_checked === exp_any) else begin
            errors++;
            $error("FAIL %s any_checked got %b exp %b", tag, any_checked, exp_any);
        end
    endtask

    task automatic chk_cnt(input string tag, input int ch);
        logic [3:0] c;
        c = dut.cnt_q[ch];
        checks++;
        assert (c === 4'd3) else begin
            errors++;
            $error("FAIL %s cnt got %0d exp 3", tag, c);
        end
    endtask

    initial begin
        reset = 1'b1; enabling = 1'b0; check = 2'b10; mode = 2'b00; clear = 1'b0;
        #1;
        chk("reset_t0", 2'b00);
        tick();
        tick();
        chk("reset_held", 2'b00);

        // Level mode after reset release
        reset = 1'b0;
        tick(); chk("level_e1", 2'b10);
        check = 2'b01;
        tick(); chk("level_e2", 2'b01);

        // Sticky mode: single pulse on channel 0, held until clear
        mode = 2'b01; check = 2'b00;
        tick(); chk("sticky_modechg", 2'b00);
        check = 2'b01;
        tick(); chk("sticky_pulse", 2'b01);
        check = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("sticky_hold", 2'b01);
        end
        clear = 1'b1;
        tick(); chk("sticky_clear", 2'b00);
        clear = 1'b0;
        tick(); chk("sticky_after_clear", 2'b00);

        // Clear and input together: clear wins, capture on next edge
        clear = 1'b1; check = 2'b11;
        tick(); chk("clear_vs_e", 2'b00);
        clear = 1'b0;
        tick(); chk("capture_after_clear", 2'b11);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1 chk("async_reset", 2'b00);
        #2 reset = 1'b0;
        tick(); chk("post_reset_modechg", 2'b00);
        tick(); chk("post_reset_sticky", 2'b11);

        // Edge mode via global force
        mode = 2'b10; check = 2'b00; enabling = 1'b0;
        tick(); chk("edge_modechg", 2'b00);
        enabling = 1'b1;
        tick(); chk("edge_rise", 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("edge_held", 2'b00);
        end
        enabling = 1'b0;
        tick(); chk("edge_fall", 2'b00);
        enabling = 1'b1;
        tick(); chk("edge_rise2", 2'b11);
        tick(); chk("edge_rise2_end", 2'b00);

        // Mode change with input high: level, then back into edge without a pulse
        mode = 2'b00;
        tick(); chk("to_level_modechg", 2'b00);
        tick(); chk("to_level_capture", 2'b11);
        mode = 2'b10;
        tick(); chk("to_edge_modechg", 2'b00);
        tick(); chk("to_edge_no_pulse", 2'b00);

        // Qualified mode, THRESH=3
        enabling = 1'b0; check = 2'b00; mode = 2'b11;
        tick(); chk("qual_modechg", 2'b00);
        check = 2'b10;
        tick(); chk("qual_b1_c1", 2'b00);
        tick(); chk("qual_b1_c2", 2'b00);
        check = 2'b00;
        tick(); chk("qual_dropout", 2'b00);
        check = 2'b10;
        tick(); chk("qual_b2_c1", 2'b00);
        tick(); chk("qual_b2_c2", 2'b00);
        tick(); chk("qual_b2_c3", 2'b10);
        tick(); chk("qual_b2_c4", 2'b10);
        chk_cnt("qual_sat_ch1", 1);
        check = 2'b00;
        tick(); chk("qual_fall", 2'b00);

        // Long run on both channels: saturation, no wrap
        check = 2'b11;
        tick(); chk("qual_long_1", 2'b00);
        tick(); chk("qual_long_2", 2'b00);
        for (int i = 0; i < 6; i++) begin
            tick(); chk("qual_long_hold", 2'b11);
        end
        chk_cnt("qual_long_ch0", 0);
        chk_cnt("qual_long_ch1", 1);
        clear = 1'b1;
        tick(); chk("qual_clear", 2'b00);
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
